// File: rtl/cve2_pkg.sv
// Shared types for the registered writeback stage.
// Holds the WB pipeline register entry, the load queue entry and a small
// register-address helper used by both the ID and LSU write paths.
package cve2_pkg;

  localparam int unsigned DataWidthDef = 32;
  localparam int unsigned RegAddrWDef  = 5;

  // One completed ID instruction waiting to be written back.
  typedef struct packed {
    logic [RegAddrWDef-1:0]  waddr_a;
    logic [DataWidthDef-1:0] wdata_a;
    logic                    we_a;
    logic [RegAddrWDef-1:0]  waddr_b;
    logic [DataWidthDef-1:0] wdata_b;
    logic                    we_b;
    logic                    perf;
    logic                    compressed;
  } wb_entry_t;

  // One outstanding load, in issue order.
  typedef struct packed {
    logic [RegAddrWDef-1:0] waddr;
    logic                   compressed;
    logic                   perf;
  } lq_entry_t;

  // x0 is hard-wired to zero, so any write aimed at it is dropped.
  function automatic logic is_x0(input logic [RegAddrWDef-1:0] addr);
    return (addr == {RegAddrWDef{1'b0}});
  endfunction

endpackage

// File: rtl/cve2_wb_load_queue.sv
// In-order FIFO of outstanding load destinations.
// Push and pop in the same cycle are legal even when full; a pop on an
// empty queue and a push into a full queue without a pop are ignored.
module cve2_wb_load_queue
  import cve2_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  lq_entry_t push_data_i,
  output lq_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  lq_entry_t          mem_r [Depth];
  logic [PtrW-1:0]    wr_ptr_r;
  logic [PtrW-1:0]    rd_ptr_r;
  logic [CntW-1:0]    count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  assign empty_o   = (count_r == {CntW{1'b0}});
  assign full_o    = (count_r == CntW'(Depth));
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign head_o    = mem_r[rd_ptr_r];

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cve2_wb_stage_checker.sv
// Protocol checks for the writeback stage: load-queue overflow, responses
// without an outstanding load, and single-source ownership of RF port A.
module cve2_wb_stage_checker (
  input logic clk_i,
  input logic rst_ni,
  input logic load_req,
  input logic load_ready,
  input logic resp_valid,
  input logic queue_empty,
  input logic src_lsu,
  input logic src_wb
);

  push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    load_req |-> load_ready);

  resp_without_load: assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_valid |-> !queue_empty);

  port_a_one_source: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({src_lsu, src_wb}));

endmodule

// File: rtl/cve2_wb_stage.sv
// Registered writeback stage between ID/EX and the register file.
// One WB register for ID results, an in-order load destination queue, and
// arbitration of RF port A where LSU responses take priority.
// Optional feature macro: CVE2_WB_FORWARD_EN (WB-register forward to ID).
// DataWidth/RegAddrW must match the widths used by cve2_pkg.
module cve2_wb_stage
  import cve2_pkg::*;
#(
  parameter int unsigned DataWidth  = DataWidthDef,
  parameter int unsigned RegAddrW   = RegAddrWDef,
  parameter int unsigned LoadQDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_wb_i,
  output logic                 wb_ready_o,
  input  logic                 instr_is_compressed_id_i,
  input  logic                 instr_perf_count_id_i,
  input  logic [RegAddrW-1:0]  rf_waddr_a_id_i,
  input  logic [DataWidth-1:0] rf_wdata_a_id_i,
  input  logic                 rf_we_a_id_i,
  input  logic [RegAddrW-1:0]  rf_waddr_b_id_i,
  input  logic [DataWidth-1:0] rf_wdata_b_id_i,
  input  logic                 rf_we_b_id_i,
  input  logic                 lsu_load_req_i,
  input  logic [RegAddrW-1:0]  lsu_load_waddr_i,
  output logic                 lsu_load_ready_o,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  input  logic [DataWidth-1:0] rf_wdata_lsu_i,
  output logic [RegAddrW-1:0]  rf_waddr_a_wb_o,
  output logic [DataWidth-1:0] rf_wdata_a_wb_o,
  output logic                 rf_we_a_wb_o,
  output logic [RegAddrW-1:0]  rf_waddr_b_wb_o,
  output logic [DataWidth-1:0] rf_wdata_b_wb_o,
  output logic                 rf_we_b_wb_o,
  output logic                 perf_instr_ret_wb_o,
  output logic                 perf_instr_ret_compressed_wb_o,
  output logic                 fwd_valid_o,
  output logic [RegAddrW-1:0]  fwd_waddr_o,
  output logic [DataWidth-1:0] fwd_wdata_o,
  output logic                 load_pending_o
);

  wb_entry_t wb_r;
  wb_entry_t wb_next_s;
  logic      wb_valid_r;
  logic      drain_s;
  logic      capture_s;
  logic      lsu_pop_s;
  logic      lsu_ok_s;
  lq_entry_t lq_push_s;
  lq_entry_t lq_head_s;
  logic      lq_empty_s;
  logic      lq_full_s;

  // An LSU response owns port A that cycle, so the WB register must wait.
  assign drain_s          = wb_valid_r & ~lsu_resp_valid_i;
  assign wb_ready_o       = ~wb_valid_r | drain_s;
  assign capture_s        = en_wb_i & wb_ready_o;
  assign lsu_pop_s        = lsu_resp_valid_i & ~lq_empty_s;
  assign lsu_ok_s         = lsu_pop_s & ~lsu_resp_err_i;
  assign lsu_load_ready_o = ~lq_full_s | lsu_resp_valid_i;
  assign load_pending_o   = ~lq_empty_s;

  assign lq_push_s.waddr      = lsu_load_waddr_i;
  assign lq_push_s.compressed = instr_is_compressed_id_i;
  assign lq_push_s.perf       = instr_perf_count_id_i;

  cve2_wb_load_queue #(
    .Depth (LoadQDepth)
  ) u_load_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (lsu_load_req_i & lsu_load_ready_o),
    .pop_i       (lsu_pop_s),
    .push_data_i (lq_push_s),
    .head_o      (lq_head_s),
    .empty_o     (lq_empty_s),
    .full_o      (lq_full_s)
  );

  // Build the entry to capture; writes to x0 are stored as non-writes.
  always_comb begin
    wb_next_s            = '0;
    wb_next_s.waddr_a    = rf_waddr_a_id_i;
    wb_next_s.wdata_a    = rf_wdata_a_id_i;
    wb_next_s.we_a       = rf_we_a_id_i & ~is_x0(rf_waddr_a_id_i);
    wb_next_s.waddr_b    = rf_waddr_b_id_i;
    wb_next_s.wdata_b    = rf_wdata_b_id_i;
    wb_next_s.we_b       = rf_we_b_id_i & ~is_x0(rf_waddr_b_id_i);
    wb_next_s.perf       = instr_perf_count_id_i;
    wb_next_s.compressed = instr_is_compressed_id_i;
  end

  // WB pipeline register: capture wins over drain so 1/cycle throughput holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_r       <= '0;
      wb_valid_r <= 1'b0;
    end else if (capture_s) begin
      wb_r       <= wb_next_s;
      wb_valid_r <= 1'b1;
    end else if (drain_s) begin
      wb_valid_r <= 1'b0;
    end else begin
      wb_valid_r <= wb_valid_r;
    end
  end

  // RF port arbitration and retire pulses; idle ports drive zero.
  always_comb begin
    rf_waddr_a_wb_o                = '0;
    rf_wdata_a_wb_o                = '0;
    rf_we_a_wb_o                   = 1'b0;
    rf_waddr_b_wb_o                = '0;
    rf_wdata_b_wb_o                = '0;
    rf_we_b_wb_o                   = 1'b0;
    perf_instr_ret_wb_o            = 1'b0;
    perf_instr_ret_compressed_wb_o = 1'b0;
    if (lsu_pop_s) begin
      rf_waddr_a_wb_o                = lq_head_s.waddr;
      rf_wdata_a_wb_o                = rf_wdata_lsu_i;
      rf_we_a_wb_o                   = lsu_ok_s & ~is_x0(lq_head_s.waddr);
      perf_instr_ret_wb_o            = lsu_ok_s & lq_head_s.perf;
      perf_instr_ret_compressed_wb_o = lsu_ok_s & lq_head_s.perf & lq_head_s.compressed;
    end else if (drain_s) begin
      rf_waddr_a_wb_o                = wb_r.waddr_a;
      rf_wdata_a_wb_o                = wb_r.wdata_a;
      rf_we_a_wb_o                   = wb_r.we_a;
      rf_waddr_b_wb_o                = wb_r.waddr_b;
      rf_wdata_b_wb_o                = wb_r.wdata_b;
      rf_we_b_wb_o                   = wb_r.we_b;
      perf_instr_ret_wb_o            = wb_r.perf;
      perf_instr_ret_compressed_wb_o = wb_r.perf & wb_r.compressed;
    end else begin
      rf_we_a_wb_o = 1'b0;
    end
  end

`ifdef CVE2_WB_FORWARD_EN
  assign fwd_valid_o = wb_valid_r & wb_r.we_a;
  assign fwd_waddr_o = wb_r.waddr_a;
  assign fwd_wdata_o = wb_r.wdata_a;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_waddr_o = '0;
  assign fwd_wdata_o = '0;
`endif

  cve2_wb_stage_checker u_checker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_req    (lsu_load_req_i),
    .load_ready  (lsu_load_ready_o),
    .resp_valid  (lsu_resp_valid_i),
    .queue_empty (lq_empty_s),
    .src_lsu     (lsu_pop_s),
    .src_wb      (drain_s)
  );

endmodule

// File: tb/tb_cve2_wb_stage.sv
// Directed-vector bench for cve2_wb_stage with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_cve2_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          en_wb, wb_ready, comp, perf;
  logic [AW-1:0] waddr_a, waddr_b, ld_waddr;
  logic [DW-1:0] wdata_a, wdata_b, lsu_data;
  logic          we_a, we_b, ld_req, ld_ready, resp_valid, resp_err;
  logic [AW-1:0] o_waddr_a, o_waddr_b, f_waddr;
  logic [DW-1:0] o_wdata_a, o_wdata_b, f_wdata;
  logic          o_we_a, o_we_b, ret, ret_c, f_valid, pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cve2_wb_stage #(.DataWidth(DW), .RegAddrW(AW), .LoadQDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_wb_i(en_wb), .wb_ready_o(wb_ready),
    .instr_is_compressed_id_i(comp), .instr_perf_count_id_i(perf),
    .rf_waddr_a_id_i(waddr_a), .rf_wdata_a_id_i(wdata_a), .rf_we_a_id_i(we_a),
    .rf_waddr_b_id_i(waddr_b), .rf_wdata_b_id_i(wdata_b), .rf_we_b_id_i(we_b),
    .lsu_load_req_i(ld_req), .lsu_load_waddr_i(ld_waddr), .lsu_load_ready_o(ld_ready),
    .lsu_resp_valid_i(resp_valid), .lsu_resp_err_i(resp_err), .rf_wdata_lsu_i(lsu_data),
    .rf_waddr_a_wb_o(o_waddr_a), .rf_wdata_a_wb_o(o_wdata_a), .rf_we_a_wb_o(o_we_a),
    .rf_waddr_b_wb_o(o_waddr_b), .rf_wdata_b_wb_o(o_wdata_b), .rf_we_b_wb_o(o_we_b),
    .perf_instr_ret_wb_o(ret), .perf_instr_ret_compressed_wb_o(ret_c),
    .fwd_valid_o(f_valid), .fwd_waddr_o(f_waddr), .fwd_wdata_o(f_wdata),
    .load_pending_o(pending)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".we_a"}, 64'(o_we_a), 64'(we));
    chk({tag, ".waddr_a"}, 64'(o_waddr_a), 64'(a));
    chk({tag, ".wdata_a"}, 64'(o_wdata_a), 64'(d));
  endtask

  task automatic chk_ret(input string tag, input logic r, input logic rc);
    chk({tag, ".ret"}, 64'(ret), 64'(r));
    chk({tag, ".ret_c"}, 64'(ret_c), 64'(rc));
  endtask

  // Expected forward depends on whether the feature is built in.
  task automatic chk_fwd(input string tag, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef CVE2_WB_FORWARD_EN
    chk({tag, ".fwd_valid"}, 64'(f_valid), 64'(v));
    chk({tag, ".fwd_waddr"}, 64'(f_waddr), 64'(a));
    chk({tag, ".fwd_wdata"}, 64'(f_wdata), 64'(d));
`else
    chk({tag, ".fwd_valid"}, 64'(f_valid), 64'(v & 1'b0));
    chk({tag, ".fwd_waddr"}, 64'(f_waddr), 64'(a & 5'd0));
    chk({tag, ".fwd_wdata"}, 64'(f_wdata), 64'(d & 32'd0));
`endif
  endtask

  task automatic idle();
    en_wb = 1'b0; comp = 1'b0; perf = 1'b0;
    waddr_a = '0; wdata_a = '0; we_a = 1'b0;
    waddr_b = '0; wdata_b = '0; we_b = 1'b0;
    ld_req = 1'b0; ld_waddr = '0;
    resp_valid = 1'b0; resp_err = 1'b0; lsu_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic id_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p, input logic c);
    en_wb = 1'b1; waddr_a = a; wdata_a = d; we_a = 1'b1; perf = p; comp = c;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();

    // Reset state
    @(negedge clk);
    chk_a("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.we_b", 64'(o_we_b), 64'd0);
    chk_ret("rst", 1'b0, 1'b0);
    chk("rst.wb_ready", 64'(wb_ready), 64'd1);
    chk("rst.ld_ready", 64'(ld_ready), 64'd1);
    chk("rst.pending", 64'(pending), 64'd0);
    chk_fwd("rst", 1'b0, 5'd0, 32'd0);
    rst_ni = 1'b1;

    // Basic ID write with port B, drains one cycle later
    next_cycle();
    id_write(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    we_b = 1'b1; waddr_b = 5'd6; wdata_b = 32'h11;
    @(negedge clk);
    chk("cap.wb_ready", 64'(wb_ready), 64'd1);
    chk_a("cap", 1'b0, 5'd0, 32'd0);
    next_cycle();
    @(negedge clk);
    chk_a("drain", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("drain.we_b", 64'(o_we_b), 64'd1);
    chk("drain.waddr_b", 64'(o_waddr_b), 64'd6);
    chk("drain.wdata_b", 64'(o_wdata_b), 64'h11);
    chk_ret("drain", 1'b1, 1'b0);
    chk_fwd("drain", 1'b1, 5'd5, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk_a("post", 1'b0, 5'd0, 32'd0);
    chk_ret("post", 1'b0, 1'b0);
    chk_fwd("post", 1'b0, 5'd0, 32'd0);

    // LSU response preempts a held ID write
    ld_req = 1'b1; ld_waddr = 5'd7; perf = 1'b1; comp = 1'b1;
    next_cycle();
    id_write(5'd5, 32'hCAFE0001, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold.pending", 64'(pending), 64'd1);
    next_cycle();
    resp_valid = 1'b1; lsu_data = 32'h1234;
    @(negedge clk);
    chk("hold.wb_ready", 64'(wb_ready), 64'd0);
    chk_a("hold.lsu", 1'b1, 5'd7, 32'h1234);
    chk("hold.we_b", 64'(o_we_b), 64'd0);
    chk_ret("hold.lsu", 1'b1, 1'b1);
    chk_fwd("hold", 1'b1, 5'd5, 32'hCAFE0001);
    next_cycle();
    @(negedge clk);
    chk_a("hold.id", 1'b1, 5'd5, 32'hCAFE0001);
    chk_ret("hold.id", 1'b1, 1'b0);
    chk("hold.pending0", 64'(pending), 64'd0);
    chk("hold.wb_ready1", 64'(wb_ready), 64'd1);

    // Back-to-back captures, one drain per cycle
    next_cycle();
    id_write(5'd8, 32'h1, 1'b1, 1'b1);
    next_cycle();
    id_write(5'd9, 32'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.wb_ready", 64'(wb_ready), 64'd1);
    chk_a("b2b.1", 1'b1, 5'd8, 32'h1);
    chk_ret("b2b.1", 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_a("b2b.2", 1'b1, 5'd9, 32'h2);
    chk_ret("b2b.2", 1'b0, 1'b0);

    // Fill the load queue, then an error response and a good one
    next_cycle();
    ld_req = 1'b1; ld_waddr = 5'd3; perf = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("lq1.ld_ready", 64'(ld_ready), 64'd1);
    ld_req = 1'b1; ld_waddr = 5'd4; perf = 1'b1; comp = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("lq2.ld_ready", 64'(ld_ready), 64'd0);
    chk("lq2.pending", 64'(pending), 64'd1);
    next_cycle();
    resp_valid = 1'b1; resp_err = 1'b1; lsu_data = 32'hBAD;
    @(negedge clk);
    chk("err.ld_ready", 64'(ld_ready), 64'd1);
    chk("err.we_a", 64'(o_we_a), 64'd0);
    chk_ret("err", 1'b0, 1'b0);
    next_cycle();
    resp_valid = 1'b1; lsu_data = 32'h55;
    @(negedge clk);
    chk_a("ok", 1'b1, 5'd4, 32'h55);
    chk_ret("ok", 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_ret("lq.after", 1'b0, 1'b0);
    chk("lq.pending0", 64'(pending), 64'd0);

    // Writes to x0 through ID and through a load
    id_write(5'd0, 32'hFFFF, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("x0id.we_a", 64'(o_we_a), 64'd0);
    chk_ret("x0id", 1'b1, 1'b0);
    chk_fwd("x0id", 1'b0, 5'd0, 32'hFFFF);
    ld_req = 1'b1; ld_waddr = 5'd0; perf = 1'b1;
    next_cycle();
    resp_valid = 1'b1; lsu_data = 32'h77;
    @(negedge clk);
    chk("x0ld.we_a", 64'(o_we_a), 64'd0);
    chk_ret("x0ld", 1'b1, 1'b0);

    // Async reset mid-operation discards WB register and queue
    next_cycle();
    id_write(5'd10, 32'hA5A5, 1'b1, 1'b0);
    ld_req = 1'b1; ld_waddr = 5'd11;
    next_cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst.we_a", 64'(o_we_a), 64'd0);
    chk("mrst.pending", 64'(pending), 64'd0);
    chk("mrst.wb_ready", 64'(wb_ready), 64'd1);
    chk_ret("mrst", 1'b0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("mrst.after.we_a", 64'(o_we_a), 64'd0);
    chk("mrst.after.pending", 64'(pending), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
